elevator_ctrl: RTL and testbench

//   Top-level sequencer for one 4-level elevator car. Owns the request-queue registers and the car position.

---
 rtl/elevator_ctrl_if.sv | 23 ++
 rtl/elevator_ctrl.sv | 136 +++++++++++++
 tb/tb_elevator_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_ctrl_if.sv
// Button-request handshake and car status bundle shared by requester and controller.
// The controller drives everything except btn_valid/btn_lvl.
interface elevator_ctrl_if;
  logic       btn_valid;
  logic [1:0] btn_lvl;
  logic       btn_ready;
  logic [1:0] pos_lvl;
  logic       moving;
  logic       dir_up;
  logic       door_open;
  logic [7:0] queue;
  logic [2:0] tail;

  modport master (
    output btn_valid, btn_lvl,
    input  btn_ready, pos_lvl, moving, dir_up, door_open, queue, tail
  );

  modport slave (
    input  btn_valid, btn_lvl,
    output btn_ready, pos_lvl, moving, dir_up, door_open, queue, tail
  );
endinterface

// File: rtl/elevator_ctrl.sv
// Four-level elevator car sequencer with its combinational request-queue datapath.
// queue_logic appends a press first, then removes the entry for the current level.
module queue_logic (
  input  logic [7:0] i_queue,
  input  logic [2:0] i_tail,
  input  logic       i_pressed_en,
  input  logic [1:0] i_pressed_lvl,
  input  logic [1:0] i_pos_lvl,
  output logic [7:0] o_next_queue_sub,
  output logic [2:0] o_next_tail_sub,
  output logic       o_stop_at_pos_lvl
);
  logic [1:0] w_q [0:4];
  logic [2:0] w_cnt;
  logic       w_dup;
  logic       w_hit;

  always_comb begin
    for (int i = 0; i < 4; i++) w_q[i] = i_queue[2*i +: 2];
    w_q[4] = 2'd0;
    w_dup  = 1'b0;
    for (int i = 0; i < 4; i++)
      if (3'(i) < i_tail && w_q[i] == i_pressed_lvl) w_dup = 1'b1;
    w_cnt = i_tail;
    if (i_pressed_en && !w_dup && i_tail < 3'd4) begin
      w_q[i_tail[1:0]] = i_pressed_lvl;
      w_cnt            = i_tail + 3'd1;
    end
    // Entries are unique, so at most one hit; everything above it shifts down.
    w_hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < w_cnt && w_q[i] == i_pos_lvl) w_hit = 1'b1;
      if (w_hit) w_q[i] = w_q[i+1];
    end
    if (w_hit) w_cnt = w_cnt - 3'd1;
    o_stop_at_pos_lvl = w_hit;
    o_next_tail_sub   = w_cnt;
    for (int i = 0; i < 4; i++) o_next_queue_sub[2*i +: 2] = w_q[i];
  end
endmodule

module elevator_ctrl #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int TW            = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  elevator_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MOVING, CHECK, DOOR} state_t;

  state_t        r_state;
  logic [1:0]    r_pos;
  logic [7:0]    r_queue;
  logic [2:0]    r_tail;
  logic [TW-1:0] r_timer;
  logic          r_dir_up;

  logic       w_ready;
  logic       w_press_en;
  logic       w_stop;
  logic [7:0] w_next_queue;
  logic [2:0] w_next_tail;

  // A press for the level being left waits until the car reaches the next level.
  assign w_ready    = !(r_state == MOVING && bus.btn_lvl == r_pos);
  assign w_press_en = bus.btn_valid & w_ready;

  queue_logic u_queue (
    .i_queue           (r_queue),
    .i_tail            (r_tail),
    .i_pressed_en      (w_press_en),
    .i_pressed_lvl     (bus.btn_lvl),
    .i_pos_lvl         (r_pos),
    .o_next_queue_sub  (w_next_queue),
    .o_next_tail_sub   (w_next_tail),
    .o_stop_at_pos_lvl (w_stop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pos    <= 2'd0;
      r_queue  <= 8'd0;
      r_tail   <= 3'd0;
      r_timer  <= '0;
      r_dir_up <= 1'b0;
    end else begin
      r_queue <= w_next_queue;
      r_tail  <= w_next_tail;
      case (r_state)
        IDLE, CHECK: begin
          r_timer <= '0;
          if (w_stop) begin
            r_state <= DOOR;
          end else if (r_tail != 3'd0) begin
            r_state  <= MOVING;
            r_dir_up <= (r_queue[1:0] > r_pos);
          end else begin
            r_state <= IDLE;
          end
        end
        MOVING: begin
          if (r_timer == TW'(TRAVEL_CYCLES - 1)) begin
            assert (r_dir_up ? (r_pos != 2'd3) : (r_pos != 2'd0));
            r_pos   <= r_dir_up ? r_pos + 2'd1 : r_pos - 2'd1;
            r_timer <= '0;
            r_state <= CHECK;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DOOR: begin
          if (w_stop) begin
            r_timer <= '0;
          end else if (r_timer == TW'(DOOR_CYCLES - 1)) begin
            r_timer <= '0;
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.btn_ready = w_ready;
  assign bus.pos_lvl   = r_pos;
  assign bus.moving    = (r_state == MOVING);
  assign bus.dir_up    = r_dir_up;
  assign bus.door_open = (r_state == DOOR);
  assign bus.queue     = r_queue;
  assign bus.tail      = r_tail;
endmodule

// File: tb/tb_elevator_ctrl.sv
// Bench for elevator_ctrl: queue-based reference model checked every cycle,
// a timing table for the basic trip, directed corner sequences and random presses.
module tb_elevator_ctrl;
  localparam int TC = 8;
  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  elevator_ctrl_if bus();
  elevator_ctrl #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .TW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  logic       valid = 1'b0;
  logic [1:0] lvl   = 2'd0;
  assign bus.btn_valid = valid;
  assign bus.btn_lvl   = lvl;

  // Reference model: list of pending levels, car level, phase 0 idle/1 moving/2 check/3 door.
  int mq[$];
  int mpos, mph, mt;
  bit mdir;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [1:0] pos;
    logic       mv;
    logic       dr;
    logic [2:0] tail;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mpack();
    logic [7:0] p = 8'd0;
    foreach (mq[i]) p[2*i +: 2] = 2'(mq[i]);
    return p;
  endfunction

  task automatic model_reset();
    mq.delete();
    mpos = 0; mph = 0; mt = 0; mdir = 1'b0;
  endtask

  // One clock: advance model from the rules, let the DUT take the edge, compare.
  task automatic step();
    int  osz, ohead, k;
    bit  rdy, acc, dup, stop;
    osz   = mq.size();
    ohead = (osz != 0) ? mq[0] : 0;
    rdy   = !(mph == 1 && int'(lvl) == mpos);
    acc   = valid && rdy;
    if (acc) begin
      dup = 1'b0;
      foreach (mq[i]) if (mq[i] == int'(lvl)) dup = 1'b1;
      if (!dup && mq.size() < 4) mq.push_back(int'(lvl));
    end
    k = -1;
    foreach (mq[i]) if (mq[i] == mpos) k = i;
    stop = (k >= 0);
    if (stop) mq.delete(k);
    case (mph)
      0, 2: begin
        mt = 0;
        if (stop) mph = 3;
        else if (osz != 0) begin mph = 1; mdir = (ohead > mpos); end
        else mph = 0;
      end
      1: begin
        if (mt == TC - 1) begin mpos += mdir ? 1 : -1; mt = 0; mph = 2; end
        else mt++;
      end
      default: begin
        if (stop) mt = 0;
        else if (mt == DC - 1) begin mt = 0; mph = 0; end
        else mt++;
      end
    endcase
    @(posedge clk);
    #1;
    if (acc) begin
      $display("press lvl=%0d accepted t=%0t pos=%0d tail=%0d", lvl, $time, mpos, mq.size());
      valid = 1'b0;
    end
    chk("pos_lvl", 32'(bus.pos_lvl), 32'(mpos));
    chk("moving", 32'(bus.moving), 32'(mph == 1));
    chk("door_open", 32'(bus.door_open), 32'(mph == 3));
    chk("tail", 32'(bus.tail), 32'(mq.size()));
    chk("queue", 32'(bus.queue), 32'(mpack()));
    chk("btn_ready", 32'(bus.btn_ready), 32'(!(mph == 1 && int'(lvl) == mpos)));
    if (mph == 1) chk("dir_up", 32'(bus.dir_up), 32'(mdir));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pos", 32'(bus.pos_lvl), 0);
    chk("rst_moving", 32'(bus.moving), 0);
    chk("rst_door", 32'(bus.door_open), 0);
    chk("rst_tail", 32'(bus.tail), 0);
    chk("rst_ready", 32'(bus.btn_ready), 1);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic [1:0] l);
    int n = 0;
    valid = 1'b1;
    lvl   = l;
    while (valid && n < 30) begin step(); n++; end
    chk("press_accepted", 32'(valid), 0);
    valid = 1'b0;
  endtask

  task automatic wait_moving();
    int n = 0;
    while (!bus.moving && n < 30) begin step(); n++; end
    chk("moving_reached", 32'(bus.moving), 1);
  endtask

  task automatic wait_door(input int exp_pos);
    int n = 0;
    while (bus.door_open && n < 100) begin step(); n++; end
    while (!bus.door_open && n < 100) begin step(); n++; end
    chk("door_reached", 32'(bus.door_open), 1);
    chk("door_pos", 32'(bus.pos_lvl), 32'(exp_pos));
  endtask

  initial begin
    int n;
    tbl[0] = '{1,  2'd0, 1'b0, 1'b0, 3'd1};
    tbl[1] = '{2,  2'd0, 1'b1, 1'b0, 3'd1};
    tbl[2] = '{9,  2'd0, 1'b1, 1'b0, 3'd1};
    tbl[3] = '{10, 2'd1, 1'b0, 1'b0, 3'd1};
    tbl[4] = '{11, 2'd1, 1'b1, 1'b0, 3'd1};
    tbl[5] = '{19, 2'd2, 1'b0, 1'b0, 3'd1};
    tbl[6] = '{20, 2'd2, 1'b0, 1'b1, 3'd0};
    tbl[7] = '{23, 2'd2, 1'b0, 1'b1, 3'd0};
    tbl[8] = '{24, 2'd2, 1'b0, 1'b0, 3'd0};

    // Basic trip to level 2, checked against the timing table.
    do_reset();
    valid = 1'b1;
    lvl   = 2'd2;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) chk("t1_queue", 32'(bus.queue), 32'h02);
      foreach (tbl[i]) begin
        if (tbl[i].cyc == c) begin
          chk("tbl_pos", 32'(bus.pos_lvl), 32'(tbl[i].pos));
          chk("tbl_moving", 32'(bus.moving), 32'(tbl[i].mv));
          chk("tbl_door", 32'(bus.door_open), 32'(tbl[i].dr));
          chk("tbl_tail", 32'(bus.tail), 32'(tbl[i].tail));
        end
      end
    end

    // Same-level press opens the door; a re-press at door cycle 2 extends it.
    do_reset();
    press(2'd0);
    chk("t2_door", 32'(bus.door_open), 1);
    chk("t2_tail", 32'(bus.tail), 0);
    step();
    step();
    press(2'd0);
    n = 0;
    while (bus.door_open && n < 10) begin step(); n++; end
    chk("t2_extend_cycles", 32'(n), 4);

    // Intermediate level pressed mid-hop causes a pass-through stop.
    do_reset();
    press(2'd3);
    wait_moving();
    repeat (3) step();
    press(2'd1);
    wait_door(1);
    wait_door(3);
    repeat (6) step();
    chk("t3_final_tail", 32'(bus.tail), 0);

    // Press for the level being left stalls until arrival at the next level.
    do_reset();
    press(2'd1);
    wait_moving();
    press(2'd0);
    chk("t4_accept_pos", 32'(bus.pos_lvl), 1);
    chk("t4_accept_door", 32'(bus.door_open), 1);
    wait_door(0);

    // Back-to-back presses with a duplicate.
    do_reset();
    press(2'd1);
    press(2'd2);
    press(2'd3);
    press(2'd2);
    chk("t5_tail", 32'(bus.tail), 3);
    wait_door(1);
    wait_door(2);
    wait_door(3);

    // Asynchronous reset mid-hop.
    do_reset();
    press(2'd3);
    wait_moving();
    repeat (5) step();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_pos", 32'(bus.pos_lvl), 0);
    chk("t6_moving", 32'(bus.moving), 0);
    chk("t6_tail", 32'(bus.tail), 0);
    chk("t6_queue", 32'(bus.queue), 0);
    chk("t6_dir", 32'(bus.dir_up), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) step();

    // Random presses, held until accepted.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!valid && $urandom_range(0, 99) < 15) begin
        valid = 1'b1;
        lvl   = 2'($urandom_range(0, 3));
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
